// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM states and the well-known instruction words.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] EBREAK = 32'h0010_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new instruction, flush the valid bit,
// or hold. Load wins over flush.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  // Register update: reset, capture, flush, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, RUN/HALT FSM, redirect and halt handling.
// Optional macro FETCH_MISALIGN_CHECK_EN traps misaligned redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 30
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        halted,
  output logic        misalign
);

  localparam logic [31:0] WORDS = 32'(IMEM_WORDS);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         run;
  logic         in_range;
  logic         capture;
  logic         is_ebreak;
  logic         bad_target;
  logic         flush;

  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign run       = (state == RUN);
  assign in_range  = (pc >> 2) < WORDS;
  assign is_ebreak = (imem_instr == EBREAK);

  assign capture = run && !redirect_valid && in_range
                && (id_ready || !id_valid);

  // In RUN a redirect flushes; in HALT an accepted instruction retires
  assign flush = run ? redirect_valid : (id_valid && id_ready);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Sticky misaligned-redirect flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (run && bad_target) begin
      misalign <= 1'b1;
    end
  end
`else
  assign bad_target = 1'b0;
  assign misalign   = 1'b0;
`endif

  // PC and FSM: redirect beats range check beats capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (redirect_valid) begin
            if (bad_target) begin
              state <= HALT;
            end else begin
              pc <= redirect_pc;
            end
          end else if (!in_range) begin
            state <= HALT;
          end else if (capture) begin
            if (is_ebreak) begin
              state <= HALT;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (capture),
    .flush      (flush),
    .load_pc    (pc),
    .load_instr (imem_instr),
    .valid      (id_valid),
    .pc         (id_pc),
    .instr      (id_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: two instances (30-word and 4-word ROM)
// compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam logic [31:0] EBRK  = 32'h0010_0073;

  typedef struct {
    logic [31:0] pc;
    logic        halt;
    logic        v;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic        mis;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] addr_a, instr_a, pc_a, ins_a;
  logic        valid_a, halted_a, mis_a;
  logic [31:0] addr_b, instr_b, pc_b, ins_b;
  logic        valid_b, halted_b, mis_b;

  logic [31:0] rom [0:63];

  int   checks;
  int   failures;
  exp_t q[$];
  mdl_t ma, mb;

  assign instr_a = (addr_a[31:2] < 30'd64) ? rom[addr_a[7:2]] : NOP_W;
  assign instr_b = (addr_b[31:2] < 30'd64) ? rom[addr_b[7:2]] : NOP_W;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(30)) dut_a (
    .clk(clk), .rst(rst), .imem_addr(addr_a), .imem_instr(instr_a),
    .id_ready(id_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(valid_a), .id_pc(pc_a),
    .id_instr(ins_a), .halted(halted_a), .misalign(mis_a)
  );

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_b (
    .clk(clk), .rst(rst), .imem_addr(addr_b), .imem_instr(instr_b),
    .id_ready(id_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(valid_b), .id_pc(pc_b),
    .id_instr(ins_b), .halted(halted_b), .misalign(mis_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_word(logic [31:0] a);
    if (a[31:2] < 30'd64) return rom[a[7:2]];
    return NOP_W;
  endfunction

  // Behavioural fetch rules, one clock edge at a time
  function automatic mdl_t step(mdl_t m, bit r, bit rdy, bit rv,
                                logic [31:0] rpc, int words);
    mdl_t n = m;
    logic [31:0] w;
    if (r) begin
      n.pc = 32'h0; n.halt = 1'b0; n.v = 1'b0;
      n.ipc = 32'h0; n.ins = NOP_W; n.mis = 1'b0;
    end else if (m.halt) begin
      if (m.v && rdy) n.v = 1'b0;
    end else if (rv) begin
      n.v = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) begin
        n.mis = 1'b1; n.halt = 1'b1;
      end else begin
        n.pc = rpc;
      end
`else
      n.pc = rpc;
`endif
    end else if ((m.pc >> 2) >= 32'(words)) begin
      n.halt = 1'b1;
    end else if (m.v && !rdy) begin
      n = m;
    end else begin
      w = rom_word(m.pc);
      n.v = 1'b1; n.ipc = m.pc; n.ins = w;
      if (w == EBRK) n.halt = 1'b1;
      else n.pc = m.pc + 32'd4;
    end
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(bit r, bit rdy, bit rv, logic [31:0] rpc);
    exp_t e;
    @(negedge clk);
    rst = r; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    e.a = step(ma, r, rdy, rv, rpc, 30);
    e.b = step(mb, r, rdy, rv, rpc, 4);
    ma = e.a;
    mb = e.b;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: pop the expected outputs for each edge and compare
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("a.addr",   addr_a,          e.a.pc);
      chk("a.halted", 32'(halted_a),   32'(e.a.halt));
      chk("a.valid",  32'(valid_a),    32'(e.a.v));
      chk("a.id_pc",  pc_a,            e.a.ipc);
      chk("a.instr",  ins_a,           e.a.ins);
      chk("a.mis",    32'(mis_a),      32'(e.a.mis));
      chk("b.addr",   addr_b,          e.b.pc);
      chk("b.halted", 32'(halted_b),   32'(e.b.halt));
      chk("b.valid",  32'(valid_b),    32'(e.b.v));
      chk("b.id_pc",  pc_b,            e.b.ipc);
      chk("b.instr",  ins_b,           e.b.ins);
      chk("b.mis",    32'(mis_b),      32'(e.b.mis));
    end
  end

  initial begin
    logic [31:0] rpc;
    bit r, rdy, rv;
    checks = 0;
    failures = 0;
    rst = 1'b1; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 64; i++)
      rom[i] = {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
    rom[5] = EBRK;
    ma = '{default: '0};
    mb = '{default: '0};

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst.addr",   addr_a,        32'h0);
    chk("rst.valid",  32'(valid_a),  32'h0);
    chk("rst.halted", 32'(halted_a), 32'h0);

    cyc(0, 1, 0, 0);
    chk("seq.pc0", pc_a, 32'h0);
    chk("seq.v0",  32'(valid_a), 32'h1);
    cyc(0, 1, 0, 0);
    chk("seq.pc4", pc_a, 32'h4);
    cyc(0, 1, 0, 0);
    chk("seq.pc8", pc_a, 32'h8);
    chk("seq.addr12", addr_a, 32'hC);

    repeat (3) begin
      cyc(0, 0, 0, 0);
      chk("stall.pc",    pc_a,   32'h8);
      chk("stall.instr", ins_a,  rom[2]);
      chk("stall.addr",  addr_a, 32'hC);
    end
    cyc(0, 1, 0, 0);
    chk("resume.pc12", pc_a, 32'hC);

    cyc(0, 0, 0, 0);
    chk("b.range.halt", 32'(halted_b), 32'h1);
    chk("b.range.held", 32'(valid_b),  32'h1);
    chk("b.range.pc",   pc_b,          32'hC);
    chk("b.range.addr", addr_b,        32'h10);
    cyc(0, 0, 0, 0);
    chk("b.held.v", 32'(valid_b), 32'h1);
    cyc(0, 1, 0, 0);
    chk("b.accept.v", 32'(valid_b), 32'h0);

    cyc(0, 1, 0, 0);
    chk("ebrk.pc",   pc_a,          32'h14);
    chk("ebrk.halt", 32'(halted_a), 32'h1);
    chk("ebrk.addr", addr_a,        32'h14);
    cyc(0, 1, 1, 32'h40);
    chk("halt.redir.addr", addr_a,        32'h14);
    chk("halt.redir.halt", 32'(halted_a), 32'h1);
    cyc(1, 0, 0, 0);
    chk("rerst.addr", addr_a,        32'h0);
    chk("rerst.halt", 32'(halted_a), 32'h0);

    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 32'h40);
    chk("redir.v",    32'(valid_a), 32'h0);
    chk("redir.addr", addr_a,       32'h40);
    cyc(0, 1, 0, 0);
    chk("redir.pc", pc_a,          32'h40);
    chk("redir.vv", 32'(valid_a),  32'h1);

    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 32'h22);
    chk("mis.v", 32'(valid_a), 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis.flag", 32'(mis_a),    32'h1);
    chk("mis.halt", 32'(halted_a), 32'h1);
`else
    chk("mis.addr", addr_a,     32'h22);
    chk("mis.flag", 32'(mis_a), 32'h0);
`endif

    for (int k = 0; k < 600; k++) begin
      r   = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = 32'($urandom_range(0, 47)) << 2;
      if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      cyc(r, rdy, rv, rpc);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("drain", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
